seven_segment_scan_controller: RTL and testbench

Time-multiplexes a DIGITS-wide packed BCD value onto a common-segment, active-low seven-segment display bank. It drives one digit at a time through a single shared bcd_to_seven_segment_decoder. A prescaler sets the per-digit dwell time, and a valid/ready load port feeds new values. New values are committed only at frame boundaries, so a frame never shows a mix of old and new digits. The block sits between the value producer (counter/ALU result) and the board display pins.

---
 rtl/seven_segment_pkg.sv | 23 ++
 rtl/bcd_to_seven_segment_decoder.sv | 28 ++
 rtl/seven_segment_scan_controller.sv | 142 ++++++++++++++
 tb/tb_seven_segment_scan_controller.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Segment vectors are active-low, ordered {g,f,e,d,c,b,a}.
// Optional build macro used by the controller: SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN.
package seven_segment_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;

    // Level of one anode line when its digit is not driven (active-low enables).
    localparam logic ANODE_OFF = 1'b1;

endpackage

// File: rtl/bcd_to_seven_segment_decoder.sv
// Combinational BCD nibble to active-low seven-segment pattern.
// Codes 4'hA..4'hF are not BCD digits and produce a blank pattern.
module bcd_to_seven_segment_decoder
    import seven_segment_pkg::*;
(
    input  logic [3:0] i_bcd,
    output seg_t       o_seg
);

    // Map one nibble to its segment pattern; non-decimal codes stay dark.
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Time-multiplexed driver for a bank of active-low seven-segment digits.
// One digit is driven per SCAN_DIV clocks through a single shared decoder.
// New values arrive over a valid/ready port into a shadow register and are
// copied to the display register only when the scan wraps to digit 0, so a
// frame never mixes old and new digits.
// Optional build macro: SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN blanks leading
// zero digits above digit 0 (anode stays asserted).
module seven_segment_scan_controller
    import seven_segment_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   load_bcd,
    output logic [DIGITS-1:0]     anode,
    output logic [6:0]            seven_segment,
    output logic                  frame_done
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [DIV_W-1:0]    r_div_cnt;
    logic [IDX_W-1:0]    r_digit_idx;
    logic [4*DIGITS-1:0] r_display;
    logic [4*DIGITS-1:0] r_shadow;
    logic                r_pending;
    logic                r_load_ready;
    logic [DIGITS-1:0]   r_anode;
    seg_t                r_seg;
    logic                r_frame_done;

    logic                w_tick;
    logic                w_wrap;
    logic                w_accept;
    logic                w_pending_next;
    logic [3:0]          w_nibbles [DIGITS];
    logic [3:0]          w_nibble;
    seg_t                w_dec_seg;
    logic                w_digit_blank;
    logic [DIGITS-1:0]   w_anode_next;

    assign w_tick   = (r_div_cnt == DIV_LAST);
    assign w_wrap   = w_tick && (r_digit_idx == IDX_LAST);
    assign w_accept = load_valid && r_load_ready;

    // Acceptance and commit can never coincide: acceptance needs pending=0,
    // commit needs pending=1.
    assign w_pending_next = w_accept ? 1'b1 : (w_wrap ? 1'b0 : r_pending);

    // Split the display register into per-digit nibbles and build the
    // one-cold anode pattern for the digit currently being scanned.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_nibbles[gi]    = r_display[4*gi +: 4];
            assign w_anode_next[gi] = enable && (r_digit_idx == IDX_W'(gi))
                                      ? ~ANODE_OFF : ANODE_OFF;
        end
    endgenerate

    assign w_nibble = w_nibbles[r_digit_idx];

    bcd_to_seven_segment_decoder u_decoder (
        .i_bcd (w_nibble),
        .o_seg (w_dec_seg)
    );

`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
    // w_upper_zero[i] is set when digit i and every digit above it are zero.
    logic [DIGITS-1:0] w_upper_zero;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_lz
            assign w_upper_zero[gi] = (r_display[4*DIGITS-1:4*gi] == '0);
        end
    endgenerate
    assign w_digit_blank = (r_digit_idx != '0) && w_upper_zero[r_digit_idx];
`else
    assign w_digit_blank = 1'b0;
`endif

    // Prescaler and scan pointer: advance one digit every SCAN_DIV clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt   <= '0;
            r_digit_idx <= '0;
        end else begin
            if (w_tick) begin
                r_div_cnt   <= '0;
                r_digit_idx <= (r_digit_idx == IDX_LAST) ? '0
                                                         : r_digit_idx + IDX_W'(1);
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
        end
    end

    // Load handshake into the shadow register, commit to display on wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_display    <= {DIGITS{4'hF}};
            r_shadow     <= '0;
            r_pending    <= 1'b0;
            r_load_ready <= 1'b1;
        end else begin
            if (w_wrap && r_pending) begin
                r_display <= r_shadow;
            end
            if (w_accept) begin
                r_shadow <= load_bcd;
            end
            r_pending    <= w_pending_next;
            r_load_ready <= !w_pending_next;
        end
    end

    // Registered output stage; anode and segments change on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_anode      <= {DIGITS{ANODE_OFF}};
            r_seg        <= SEG_BLANK;
            r_frame_done <= 1'b0;
        end else begin
            r_anode      <= w_anode_next;
            r_seg        <= (!enable || w_digit_blank) ? SEG_BLANK : w_dec_seg;
            r_frame_done <= w_wrap;
        end
    end

    assign load_ready    = r_load_ready;
    assign anode         = r_anode;
    assign seven_segment = r_seg;
    assign frame_done    = r_frame_done;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Testbench for seven_segment_scan_controller (DIGITS=4, SCAN_DIV=4).
// Honours SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN in its reference model.
module tb_seven_segment_scan_controller;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_bcd = 16'h0;
    logic [3:0]  anode;
    logic [6:0]  seven_segment;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    // Reference model state: cycles since reset, committed value, queued value.
    int          m_t;
    logic [15:0] m_display;
    logic [15:0] m_shadow;
    logic        m_pending;
    logic        last_acc;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    seven_segment_scan_controller #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_bcd      (load_bcd),
        .anode         (anode),
        .seven_segment (seven_segment),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [15:0] d, input int dg);
        logic [3:0] nib;
        nib = 4'((d >> (dg * 4)) & 16'hF);
        if (nib > 4'd9) return 7'h7F;
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
        if (dg > 0 && (d >> (dg * 4)) == 16'h0) return 7'h7F;
`endif
        return seg_tab[nib];
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 2) != 0)
                v[4*i +: 4] = 4'($urandom_range(0, 11));
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t       = 0;
        m_display = 16'hFFFF;
        m_shadow  = 16'h0;
        m_pending = 1'b0;
    endtask

    // One clock: predict from the pre-edge state, advance model, compare.
    task automatic step();
        int          dg;
        logic [3:0]  ea;
        logic [6:0]  es;
        logic        wrap;
        dg       = (m_t / SCAN_DIV) % DIGITS;
        ea       = enable ? ~(4'b0001 << dg) : 4'hF;
        es       = enable ? ref_seg(m_display, dg) : 7'h7F;
        wrap     = ((m_t % SCAN_DIV) == SCAN_DIV - 1) && (dg == DIGITS - 1);
        last_acc = load_valid && !m_pending;
        if (wrap && m_pending) begin
            m_display = m_shadow;
            m_pending = 1'b0;
        end
        if (last_acc) begin
            m_shadow  = load_bcd;
            m_pending = 1'b1;
            $display("load accepted value=%04h at cycle %0d", load_bcd, m_t);
        end
        m_t++;
        @(posedge clk);
        #1;
        check("anode", 32'(anode), 32'(ea));
        check("seven_segment", 32'(seven_segment), 32'(es));
        check("frame_done", 32'(frame_done), 32'(wrap));
        check("load_ready", 32'(load_ready), 32'(!m_pending));
    endtask

    // Asynchronous reset pulse between edges; outputs checked before any edge.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_anode", 32'(anode), 32'h0000000F);
        check("rst_seg", 32'(seven_segment), 32'h0000007F);
        check("rst_ready", 32'(load_ready), 32'h1);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic load_value(input logic [15:0] v);
        load_valid = 1'b1;
        load_bcd   = v;
        last_acc   = 1'b0;
        for (int i = 0; i < 40 && !last_acc; i++) step();
        check("accept_within_budget", 32'(last_acc), 32'h1);
        load_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        model_reset();
        #12;
        check("por_anode", 32'(anode), 32'h0000000F);
        check("por_seg", 32'(seven_segment), 32'h0000007F);
        check("por_ready", 32'(load_ready), 32'h1);
        check("por_frame_done", 32'(frame_done), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Load and commit, then back-pressure with a held value.
        load_value(16'h1234);
        run(20);
        load_value(16'h1234);
        load_value(16'h5678);
        run(36);

        // Invalid nibble and leading-zero patterns.
        load_value(16'h00A9);
        run(36);
        load_value(16'h0070);
        run(36);
        load_value(16'h0000);
        run(36);

        // Enable drop mid-frame, then resume.
        run(5);
        enable = 1'b0;
        run(24);
        enable = 1'b1;
        run(20);

        // Reset mid-handshake discards the queued value.
        load_value(16'h4321);
        async_reset();
        run(40);

        // Randomised traffic with occasional enable flips and resets.
        for (int i = 0; i < 1500; i++) begin
            if (!load_valid && $urandom_range(0, 5) == 0) begin
                load_valid = 1'b1;
                load_bcd   = rand_bcd();
            end
            if ($urandom_range(0, 49) == 0) enable = !enable;
            step();
            if (last_acc) load_valid = 1'b0;
            if ($urandom_range(0, 399) == 0) async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
